// File: rtl/pe_bundle_packer_pkg.sv
// Shared widths, pad coordinate and FSM state type for the PE bundle packer.
package pe_bundle_packer_pkg;
  localparam int COL_LENGTH         = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;
  localparam int PE_OUTPUT_SIZE     = 16;
  localparam int OUTPUT_COL_SIZE    = 5;
  localparam bit SKIP_ZERO          = 1'b1;

  localparam int CW    = COL_LENGTH;
  localparam int DW    = DOUBLE_WORD_LENGTH;
  localparam int LANES = PE_OUTPUT_SIZE;
  localparam int IDX_W = 5;  // fill index counts 0..LANES

  localparam logic [COL_LENGTH-1:0] PAD_COORD = 8'hFF;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  // A signed coordinate is usable when it lies in 0..OUTPUT_COL_SIZE-1.
  function automatic logic coord_in_range(input logic [CW-1:0] c);
    return !c[CW-1] && (c < CW'(OUTPUT_COL_SIZE));
  endfunction
endpackage

// File: rtl/pe_bundle_packer_if.sv
// Product stream in, bundle stream out. Both sides use valid/ready: a
// transfer happens on a rising edge where valid && ready; the sender holds
// valid and payload stable until that edge.
interface pe_bundle_packer_if;
  import pe_bundle_packer_pkg::*;

  logic                  s_valid;
  logic                  s_ready;
  logic [DW-1:0]         s_data;
  logic [CW-1:0]         s_col;
  logic [CW-1:0]         s_row;
  logic                  s_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW*LANES-1:0]   data_out;
  logic [CW*LANES-1:0]   data_out_cols;
  logic [CW*LANES-1:0]   data_out_rows;
  logic                  out_last;
  logic [15:0]           drop_cnt;

  // Environment side: produces products, consumes bundles.
  modport master (
    output s_valid, s_data, s_col, s_row, s_last, out_ready,
    input  s_ready, out_valid, data_out, data_out_cols, data_out_rows,
           out_last, drop_cnt
  );

  // Packer side.
  modport slave (
    input  s_valid, s_data, s_col, s_row, s_last, out_ready,
    output s_ready, out_valid, data_out, data_out_cols, data_out_rows,
           out_last, drop_cnt
  );
endinterface

// File: rtl/pe_bundle_packer_lane_fill.sv
// Fill buffer: writes kept products into lanes in arrival order and, on
// close, latches the padded bundle so a blocked bundle can wait here.
module pe_lane_fill
  import pe_bundle_packer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_i,
  input  logic                last_i,
  input  logic [DW-1:0]       wr_data_i,
  input  logic [CW-1:0]       wr_col_i,
  input  logic [CW-1:0]       wr_row_i,
  output logic                close_o,
  output logic [DW*LANES-1:0] close_data_o,
  output logic [CW*LANES-1:0] close_cols_o,
  output logic [CW*LANES-1:0] close_rows_o,
  output logic [DW*LANES-1:0] held_data_o,
  output logic [CW*LANES-1:0] held_cols_o,
  output logic [CW*LANES-1:0] held_rows_o
);
  logic [DW*LANES-1:0] data_q;
  logic [CW*LANES-1:0] cols_q;
  logic [CW*LANES-1:0] rows_q;
  logic [IDX_W-1:0]    idx_q;

  assign close_o = last_i || (wr_i && (idx_q == IDX_W'(LANES - 1)));

  // Bundle as it would look if closed this cycle: written lanes, the
  // incoming write, and pads everywhere else.
  always_comb begin
    close_data_o = '0;
    close_cols_o = '1;
    close_rows_o = '1;
    for (int j = 0; j < LANES; j++) begin
      if (IDX_W'(j) < idx_q) begin
        close_data_o[j*DW +: DW] = data_q[j*DW +: DW];
        close_cols_o[j*CW +: CW] = cols_q[j*CW +: CW];
        close_rows_o[j*CW +: CW] = rows_q[j*CW +: CW];
      end else if (wr_i && (IDX_W'(j) == idx_q)) begin
        close_data_o[j*DW +: DW] = wr_data_i;
        close_cols_o[j*CW +: CW] = wr_col_i;
        close_rows_o[j*CW +: CW] = wr_row_i;
      end else begin
        close_data_o[j*DW +: DW] = '0;
        close_cols_o[j*CW +: CW] = PAD_COORD;
        close_rows_o[j*CW +: CW] = PAD_COORD;
      end
    end
  end

  assign held_data_o = data_q;
  assign held_cols_o = cols_q;
  assign held_rows_o = rows_q;

  // Lane storage and fill index; close snapshots the padded bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cols_q <= '1;
      rows_q <= '1;
      idx_q  <= '0;
    end else if (close_o) begin
      data_q <= close_data_o;
      cols_q <= close_cols_o;
      rows_q <= close_rows_o;
      idx_q  <= '0;
    end else if (wr_i) begin
      for (int j = 0; j < LANES; j++) begin
        if (IDX_W'(j) == idx_q) begin
          data_q[j*DW +: DW] <= wr_data_i;
          cols_q[j*CW +: CW] <= wr_col_i;
          rows_q[j*CW +: CW] <= wr_row_i;
        end
      end
      idx_q <= idx_q + IDX_W'(1);
    end
  end
endmodule

// File: rtl/pe_bundle_packer.sv
// Packs sparse PE products into fixed-width lane bundles for the adder.
// Filters bad coordinates (counted) and zero products (silent), stalls the
// input while a closed bundle waits behind a blocked output register.
module pe_bundle_packer
  import pe_bundle_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pe_bundle_packer_if.slave  bus,
  output state_e             state_o
);
  state_e              state_q;
  logic                s_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                held_last_q;
  logic [DW*LANES-1:0] out_data_q;
  logic [CW*LANES-1:0] out_cols_q;
  logic [CW*LANES-1:0] out_rows_q;
  logic [15:0]         drop_q;

  logic                in_fire, coord_ok, data_ok, keep, last_beat, out_free, close;
  logic [DW*LANES-1:0] close_data, held_data;
  logic [CW*LANES-1:0] close_cols, close_rows, held_cols, held_rows;

  assign in_fire   = bus.s_valid && s_ready_q;
  assign coord_ok  = coord_in_range(bus.s_col) && coord_in_range(bus.s_row);
  assign data_ok   = !(SKIP_ZERO && (bus.s_data == '0));
  assign keep      = in_fire && coord_ok && data_ok;
  assign last_beat = in_fire && bus.s_last;
  assign out_free  = !out_valid_q || bus.out_ready;

  pe_lane_fill u_fill (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_i         (keep),
    .last_i       (last_beat),
    .wr_data_i    (bus.s_data),
    .wr_col_i     (bus.s_col),
    .wr_row_i     (bus.s_row),
    .close_o      (close),
    .close_data_o (close_data),
    .close_cols_o (close_cols),
    .close_rows_o (close_rows),
    .held_data_o  (held_data),
    .held_cols_o  (held_cols),
    .held_rows_o  (held_rows)
  );

  // FILL/HOLD control, output register and input ready, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      held_last_q <= 1'b0;
      out_data_q  <= '0;
      out_cols_q  <= '1;
      out_rows_q  <= '1;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          s_ready_q <= 1'b1;
          if (close) begin
            if (out_free) begin
              out_valid_q <= 1'b1;
              out_last_q  <= last_beat;
              out_data_q  <= close_data;
              out_cols_q  <= close_cols;
              out_rows_q  <= close_rows;
            end else begin
              state_q     <= HOLD;
              held_last_q <= last_beat;
              s_ready_q   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b1;
            out_last_q  <= held_last_q;
            out_data_q  <= held_data;
            out_cols_q  <= held_cols;
            out_rows_q  <= held_rows;
            state_q     <= FILL;
            s_ready_q   <= 1'b1;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Saturating count of beats rejected for out-of-range coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (in_fire && !coord_ok && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.s_ready       = s_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.data_out      = out_data_q;
  assign bus.data_out_cols = out_cols_q;
  assign bus.data_out_rows = out_rows_q;
  assign bus.drop_cnt      = drop_q;
  assign state_o           = state_q;
endmodule
